thee_clk_div_gen: RTL and testbench

- Multi-channel, synthesizable clock-divider generator; successor to the single free-running behavioural clock source.
- Produces NCH independently programmable divided clocks from one system clock, each with its own divide ratio, start phase, enable and glitch-free ratio update.
- Used by benches and by RTL needing derived clock-enable ticks, such as sampling strobes and slow peripheral clocks.

---
 rtl/thee_clk_div_gen.sv | 120 ++++++++++++
 tb/tb_thee_clk_div_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/thee_clk_div_gen.sv
// Multi-channel programmable clock divider: each channel has its own ratio, start phase, enable and glitch-free update.
// Optional macro THEE_CLK_DIV_EDGE_CNT_EN adds a per-channel rising-edge counter output (edge_cnt_o).
module thee_clk_div_gen #(
   parameter int NCH     = 4,
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en_i,
   input  logic [NCH-1:0]       ld_i,
   input  logic [NCH*DIV_W-1:0] div_i,
   input  logic [NCH*DIV_W-1:0] ph_i,
   output logic [NCH-1:0]       clk_o,
   output logic [NCH-1:0]       tick_o,
   output logic [NCH-1:0]       run_o,
   output logic [NCH-1:0]       pend_o
`ifdef THEE_CLK_DIV_EDGE_CNT_EN
   ,
   output logic [NCH*CNT_W-1:0] edge_cnt_o
`endif
);

   localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] RESET_D = DIV_W'(DEF_DIV);

   for (genvar c = 0; c < NCH; c++) begin : gCh
      logic [DIV_W-1:0] actD_q, actD_d, actP_q, actP_d;
      logic [DIV_W-1:0] pendD_q, pendD_d, pendP_q, pendP_d;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             pend_q, pend_d, run_q, run_d;
      logic             clk_q, clk_d, tick_q, tick_d;
      logic [DIV_W-1:0] effD, newEffD, highLen, startP;
      logic             wrap, apply;

      // Pending config reaches the active registers only while idle or at a period wrap,
      // so a ratio change can never produce a runt pulse.
      always_comb begin
         effD    = (actD_q < MIN_D) ? MIN_D : actD_q;
         wrap    = run_q && (cnt_q >= effD - ONE);
         apply   = pend_q && (!run_q || wrap);
         actD_d  = apply ? pendD_q : actD_q;
         actP_d  = apply ? pendP_q : actP_q;
         newEffD = (actD_d < MIN_D) ? MIN_D : actD_d;
         startP  = (actP_d >= newEffD) ? '0 : actP_d;
         highLen = newEffD - (newEffD >> 1);

         pendD_d = pendD_q;
         pendP_d = pendP_q;
         pend_d  = pend_q && !apply;
         if (ld_i[c]) begin
            pendD_d = div_i[c*DIV_W +: DIV_W];
            pendP_d = ph_i[c*DIV_W +: DIV_W];
            pend_d  = 1'b1;
         end

         run_d = run_q;
         cnt_d = cnt_q;
         if (!run_q) begin
            if (en_i[c]) begin
               run_d = 1'b1;
               cnt_d = startP;
            end
         end else if (wrap) begin
            cnt_d = '0;
            run_d = en_i[c];
         end else begin
            cnt_d = cnt_q + ONE;
         end

         clk_d  = run_d && (cnt_d < highLen);
         tick_d = run_d && (cnt_d == '0);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            actD_q  <= RESET_D;
            actP_q  <= '0;
            pendD_q <= '0;
            pendP_q <= '0;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            actD_q  <= actD_d;
            actP_q  <= actP_d;
            pendD_q <= pendD_d;
            pendP_q <= pendP_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
         end
      end

      assign clk_o[c]  = clk_q;
      assign tick_o[c] = tick_q;
      assign run_o[c]  = run_q;
      assign pend_o[c] = pend_q;

`ifdef THEE_CLK_DIV_EDGE_CNT_EN
      // Counted together with the registered tick, so the count already includes the tick on display.
      logic [CNT_W-1:0] edgeCnt_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            edgeCnt_q <= '0;
         end else begin
            edgeCnt_q <= edgeCnt_q + CNT_W'(tick_d);
         end
      end
      assign edge_cnt_o[c*CNT_W +: CNT_W] = edgeCnt_q;
`endif
   end

endmodule

// File: tb/tb_thee_clk_div_gen.sv
// Directed self-checking bench for thee_clk_div_gen (4 channels, 8-bit ratios, DEF_DIV=2).
// With THEE_CLK_DIV_EDGE_CNT_EN defined it also checks edge_cnt_o around reset.
module tb_thee_clk_div_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en, ld;
   logic [31:0] div, ph;
   logic [3:0]  clkO, tickO, runO, pendO;
`ifdef THEE_CLK_DIV_EDGE_CNT_EN
   logic [63:0] edgeCnt;
`endif
   int checks = 0;
   int passes = 0;

   thee_clk_div_gen #(.NCH(4), .DIV_W(8), .DEF_DIV(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en_i(en), .ld_i(ld), .div_i(div), .ph_i(ph),
      .clk_o(clkO), .tick_o(tickO), .run_o(runO), .pend_o(pendO)
`ifdef THEE_CLK_DIV_EDGE_CNT_EN
      , .edge_cnt_o(edgeCnt)
`endif
   );

   always #5 clk = ~clk;

   // Advance one edge and sample 1 ns later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic loadCh(input int c, input int d, input int p);
      div[c*8 +: 8] = 8'(d);
      ph[c*8 +: 8]  = 8'(p);
      ld[c] = 1'b1;
      cyc();
      ld[c] = 1'b0;
   endtask

   task automatic stopCh(input int c);
      int n;
      en[c] = 1'b0;
      n = 0;
      while (runO[c] !== 1'b0 && n < 40) begin
         cyc();
         n++;
      end
      checks++;
      if (runO[c] !== 1'b0) $display("[TB] FAIL stop_timeout ch%0d run_o=%b required 0", c, runO[c]);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '0; ld = '0; div = '0; ph = '0;
      cyc(); cyc();
      checks++;
      if ({clkO, tickO, runO, pendO} !== 16'h0) $display("[TB] FAIL reset_outputs got %h required 0000", {clkO, tickO, runO, pendO});
      else passes++;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_default_div();
      en[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++;
         if (clkO[0] !== ((i % 2) == 0) || tickO[0] !== ((i % 2) == 0) || runO[0] !== 1'b1)
            $display("[TB] FAIL def_div cyc%0d clk/tick/run=%b%b%b required %b%b1", i, clkO[0], tickO[0], runO[0], (i % 2) == 0, (i % 2) == 0);
         else passes++;
      end
   endtask

   task automatic test_div5_and_clamp();
      loadCh(1, 5, 0);
      checks++;
      if (pendO[1] !== 1'b1) $display("[TB] FAIL div5_pend got %b required 1", pendO[1]);
      else passes++;
      en[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if (clkO[1] !== ((i % 5) < 3) || tickO[1] !== ((i % 5) == 0) || pendO[1] !== 1'b0)
            $display("[TB] FAIL div5 cyc%0d clk/tick/pend=%b%b%b required %b%b0", i, clkO[1], tickO[1], pendO[1], (i % 5) < 3, (i % 5) == 0);
         else passes++;
      end
      stopCh(1);
      loadCh(1, 0, 0);
      en[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (clkO[1] !== ((i % 2) == 0) || tickO[1] !== ((i % 2) == 0))
            $display("[TB] FAIL div0_clamp cyc%0d clk/tick=%b%b required %b%b", i, clkO[1], tickO[1], (i % 2) == 0, (i % 2) == 0);
         else passes++;
      end
   endtask

   task automatic test_ratio_update();
      logic [8:0] expClk, expTick, expPend;
      expClk  = 9'b100011100;
      expTick = 9'b100000100;
      expPend = 9'b000000011;
      loadCh(2, 4, 0);
      en[2] = 1'b1;
      cyc();
      cyc();
      checks++;
      if (clkO[2] !== 1'b1) $display("[TB] FAIL upd_pre cnt1 clk=%b required 1", clkO[2]);
      else passes++;
      div[2*8 +: 8] = 8'd6;
      ld[2] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         ld[2] = 1'b0;
         checks++;
         if (clkO[2] !== expClk[i] || tickO[2] !== expTick[i] || pendO[2] !== expPend[i])
            $display("[TB] FAIL ratio_upd cyc%0d clk/tick/pend=%b%b%b required %b%b%b", i, clkO[2], tickO[2], pendO[2], expClk[i], expTick[i], expPend[i]);
         else passes++;
      end
   endtask

   task automatic test_stop_restart();
      loadCh(3, 8, 0);
      en[3] = 1'b1;
      cyc(); cyc(); cyc();
      en[3] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (runO[3] !== 1'b1 || clkO[3] !== (i == 0) || tickO[3] !== 1'b0)
            $display("[TB] FAIL stop_drain cyc%0d run/clk/tick=%b%b%b required 1%b0", i, runO[3], clkO[3], tickO[3], i == 0);
         else passes++;
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (runO[3] !== 1'b0 || clkO[3] !== 1'b0 || tickO[3] !== 1'b0)
            $display("[TB] FAIL stopped cyc%0d run/clk/tick=%b%b%b required 000", i, runO[3], clkO[3], tickO[3]);
         else passes++;
      end
      en[3] = 1'b1;
      cyc();
      en[3] = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (i == 2) en[3] = 1'b1;
         checks++;
         if (runO[3] !== 1'b1 || tickO[3] !== (i == 8))
            $display("[TB] FAIL en_glitch cyc%0d run/tick=%b%b required 1%b", i, runO[3], tickO[3], i == 8);
         else passes++;
      end
   endtask

   task automatic test_phase();
      stopCh(0);
      loadCh(0, 6, 3);
      en[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (clkO[0] !== (i == 3) || tickO[0] !== (i == 3))
            $display("[TB] FAIL phase3 cyc%0d clk/tick=%b%b required %b%b", i, clkO[0], tickO[0], i == 3, i == 3);
         else passes++;
      end
      stopCh(0);
      loadCh(0, 6, 9);
      en[0] = 1'b1;
      cyc();
      checks++;
      if (clkO[0] !== 1'b1 || tickO[0] !== 1'b1) $display("[TB] FAIL phase9_clamp clk/tick=%b%b required 11", clkO[0], tickO[0]);
      else passes++;
   endtask

   task automatic test_reset_mid();
      cyc(); cyc();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({clkO, tickO, runO, pendO} !== 16'h0) $display("[TB] FAIL async_reset got %h required 0000", {clkO, tickO, runO, pendO});
      else passes++;
`ifdef THEE_CLK_DIV_EDGE_CNT_EN
      checks++;
      if (edgeCnt !== 64'h0) $display("[TB] FAIL edge_cnt_reset got %h required 0", edgeCnt);
      else passes++;
`endif
      en = 4'b0001;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (clkO[0] !== ((i % 2) == 0) || runO[3:1] !== 3'b000)
            $display("[TB] FAIL post_reset cyc%0d clk0=%b run321=%b required %b 000", i, clkO[0], runO[3:1], (i % 2) == 0);
         else passes++;
`ifdef THEE_CLK_DIV_EDGE_CNT_EN
         checks++;
         if (edgeCnt[15:0] !== 16'(i / 2 + 1)) $display("[TB] FAIL edge_cnt cyc%0d got %0d required %0d", i, edgeCnt[15:0], i / 2 + 1);
         else passes++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_default_div();
      test_div5_and_clamp();
      test_ratio_update();
      test_stop_restart();
      test_phase();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
